// File: rtl/ram_sdp_init.sv
// ram_sdp_init: simple-dual-port byte-enabled RAM with a 1/2-cycle read pipeline,
// selectable read-during-write and a post-reset init sweep of the whole array.
module ram_sdp_init #(
    parameter int MEM_ADDR_WIDTH = 7,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_DATA_SIZE_BYTES = MEM_DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE = 0,
    parameter logic [MEM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_wr_en,
    input  logic [MEM_ADDR_WIDTH-1:0]      i_wr_addr,
    input  logic [MEM_DATA_SIZE_BYTES-1:0] i_wr_ben,
    input  logic [MEM_DATA_WIDTH-1:0]      i_wr_data,
    input  logic                           i_rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0]      i_rd_addr,
    output logic [MEM_DATA_WIDTH-1:0]      o_rd_data,
    output logic                           o_rd_valid,
    output logic                           o_init_done
);
    localparam int NUM_MEM_ADDR = 2 ** MEM_ADDR_WIDTH;
    typedef enum logic {INIT, READY} state_t;
    state_t                          state;
    logic [MEM_ADDR_WIDTH-1:0]       init_cnt;
    logic [MEM_DATA_WIDTH-1:0]       mem [NUM_MEM_ADDR];
    logic                            we, re, rd_v;
    logic [MEM_ADDR_WIDTH-1:0]       wa;
    logic [MEM_DATA_SIZE_BYTES-1:0]  wb;
    logic [MEM_DATA_WIDTH-1:0]       wd, rd_word, rd_q;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_sdp_init: READ_LATENCY must be 1 or 2");
    end
    if (MEM_DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("ram_sdp_init: MEM_DATA_WIDTH must be a multiple of 8");
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            init_cnt    <= '0;
            o_init_done <= 1'b0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
                state       <= READY;
                o_init_done <= 1'b1;
            end
        end
    end

    // The init sweep owns the write port; user requests are dropped until READY.
    always_comb begin
        we      = (state == INIT) || i_wr_en;
        wa      = (state == INIT) ? init_cnt : i_wr_addr;
        wb      = (state == INIT) ? '1 : i_wr_ben;
        wd      = (state == INIT) ? INIT_VALUE : i_wr_data;
        re      = (state == READY) && i_rd_en;
        rd_word = mem[i_rd_addr];
        for (int k = 0; k < MEM_DATA_SIZE_BYTES; k++)
            if (RDW_MODE == 1 && state == READY && i_wr_en && i_wr_ben[k] && i_wr_addr == i_rd_addr)
                rd_word[8*k +: 8] = i_wr_data[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < MEM_DATA_SIZE_BYTES; k++)
                if (wb[k]) mem[wa][8*k +: 8] <= wd[8*k +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v <= 1'b0;
            rd_q <= '0;
        end else begin
            rd_v <= re;
            if (re) rd_q <= rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                o_rd_valid <= 1'b0;
                o_rd_data  <= '0;
            end else begin
                o_rd_valid <= rd_v;
                if (rd_v) o_rd_data <= rd_q;
            end
        end
    end else begin : g_lat1
        assign o_rd_valid = rd_v;
        assign o_rd_data  = rd_q;
    end
endmodule

// File: tb/tb_ram_sdp_init.sv
// tb_ram_sdp_init: two instances (latency 2 / old-data, latency 1 / new-data) driven
// in lockstep and checked against an array model plus a directed vector table.
module tb_ram_sdp_init;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int N = 16;
    localparam logic [DW-1:0] IV = 32'hDEADBEEF;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [BW-1:0] ben;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    logic          clk = 1'b0, reset_n = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [BW-1:0] wr_ben = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1, init_done0, init_done1;
    int            errors = 0, checks = 0, rel_cnt = 0;
    logic [DW-1:0] mm [N];
    logic          ev0 = 1'b0, ev1 = 1'b0, pend_v = 1'b0;
    logic [DW-1:0] ed0 = '0, ed1 = '0, pend_d = '0, cap0, cap1;
    vec_t          tbl [10];

    always #5 clk = ~clk;

    ram_sdp_init #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_MODE(0),
                   .INIT_VALUE(IV)) u0 (
        .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_ben(wr_ben),
        .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data0),
        .o_rd_valid(rd_valid0), .o_init_done(init_done0));

    ram_sdp_init #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(1),
                   .INIT_VALUE(IV)) u1 (
        .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_ben(wr_ben),
        .i_wr_data(wr_data), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data1),
        .o_rd_valid(rd_valid1), .o_init_done(init_done1));

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_done0"}, 32'(init_done0), 32'(rel_cnt >= N));
        chk({tag, "_done1"}, 32'(init_done1), 32'(rel_cnt >= N));
        chk({tag, "_valid0"}, 32'(rd_valid0), 32'(ev0));
        chk({tag, "_valid1"}, 32'(rd_valid1), 32'(ev1));
        chk({tag, "_data0"}, rd_data0, ed0);
        chk({tag, "_data1"}, rd_data1, ed1);
    endtask

    // One clock cycle: drive at negedge, update the model, check after the rising edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] ben,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic          rdy;
        logic [DW-1:0] old, mrg, wnew;
        wr_en = we; wr_addr = wa; wr_ben = ben; wr_data = wd; rd_en = re; rd_addr = ra;
        rdy  = reset_n && rel_cnt >= N;
        old  = mm[ra];
        mrg  = old;
        wnew = mm[wa];
        for (int k = 0; k < BW; k++)
            if (ben[k]) begin
                wnew[8*k +: 8] = wd[8*k +: 8];
                if (we && wa == ra) mrg[8*k +: 8] = wd[8*k +: 8];
            end
        if (rdy && we) mm[wa] = wnew;
        @(posedge clk);
        #1;
        if (reset_n) rel_cnt++;
        ev0 = pend_v;
        if (pend_v) ed0 = pend_d;
        pend_v = rdy && re;
        pend_d = old;
        ev1 = rdy && re;
        if (ev1) ed1 = mrg;
        chk_outputs("step");
        if (rd_valid0) cap0 = rd_data0;
        if (rd_valid1) cap1 = rd_data1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        rel_cnt = 0; ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0; pend_v = 1'b0; pend_d = '0;
        for (int a = 0; a < N; a++) mm[a] = IV;
        chk_outputs("rst");
        repeat (2) idle();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [4:0]    sv;
        logic [DW-1:0] sd [5];
        tbl[0] = '{1'b1, 4'd5,  4'hF, 32'h11223344, 1'b0, 4'd0,  32'h0, 32'h0};
        tbl[1] = '{1'b1, 4'd5,  4'h5, 32'hAABBCCDD, 1'b0, 4'd0,  32'h0, 32'h0};
        tbl[2] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  32'h11BB33DD, 32'h11BB33DD};
        tbl[3] = '{1'b1, 4'd7,  4'hF, 32'h00000000, 1'b0, 4'd0,  32'h0, 32'h0};
        tbl[4] = '{1'b1, 4'd7,  4'h3, 32'hCAFEF00D, 1'b1, 4'd7,  32'h00000000, 32'h0000F00D};
        tbl[5] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd7,  32'h0000F00D, 32'h0000F00D};
        tbl[6] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd3,  IV, IV};
        tbl[7] = '{1'b1, 4'd2,  4'h0, 32'h12345678, 1'b1, 4'd2,  IV, IV};
        tbl[8] = '{1'b1, 4'd15, 4'h8, 32'hFF000000, 1'b0, 4'd0,  32'h0, 32'h0};
        tbl[9] = '{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd15, 32'hFFADBEEF, 32'hFFADBEEF};

        @(negedge clk);
        do_reset();
        // Requests during the sweep (including a write to addr 3) must be dropped.
        for (int i = 0; i < N; i++) step(1'b1, 4'd3, 4'hF, 32'h0, 1'b1, 4'(i));
        for (int i = 0; i < N; i++) step(1'b0, '0, '0, '0, 1'b1, 4'(i));
        idle();

        foreach (tbl[i]) begin
            cap0 = 'x;
            cap1 = 'x;
            step(tbl[i].we, tbl[i].wa, tbl[i].ben, tbl[i].wd, tbl[i].re, tbl[i].ra);
            idle();
            if (tbl[i].re) begin
                chk($sformatf("tbl%0d_m0", i), cap0, tbl[i].e0);
                chk($sformatf("tbl%0d_m1", i), cap1, tbl[i].e1);
            end
        end

        for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 4'hF, 32'(i * 32'h101), 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, '0, '0, i < 3, 4'(i + 1));
            sv[i] = rd_valid0;
            sd[i] = rd_data0;
        end
        chk("b2b_valid", 32'(sv), 32'b01110);
        for (int i = 1; i <= 3; i++) chk($sformatf("b2b_data%0d", i), sd[i], 32'(i * 32'h101));

        for (int i = 0; i < 50; i++)
            step(1'($urandom_range(0, 1)), 4'd0, 4'($urandom), $urandom, 1'($urandom_range(0, 1)), 4'd9);
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom));

        step(1'b0, '0, '0, '0, 1'b1, 4'd1);
        do_reset();
        for (int i = 0; i < N + 4; i++) step(1'b0, '0, '0, '0, 1'b1, 4'(i));
        cap0 = 'x;
        cap1 = 'x;
        step(1'b0, '0, '0, '0, 1'b1, 4'd1);
        idle();
        chk("post_rst_m0", cap0, IV);
        chk("post_rst_m1", cap1, IV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_sdp_init.md
Name: ram_sdp_init

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, both usable every cycle.
- Next-generation on-chip storage for the cache data/tag arrays.
- Adds a configurable read pipeline with a read-valid strobe and selectable read-during-write semantics.
- Adds a post-reset hardware initialisation sweep, so the array never needs a reset fan-out.

Parameters:
- MEM_ADDR_WIDTH, 7: address bits; depth NUM_MEM_ADDR = 2**MEM_ADDR_WIDTH.
- MEM_DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- MEM_DATA_SIZE_BYTES, MEM_DATA_WIDTH/8: number of byte-enable bits.
- READ_LATENCY, 1: read latency in cycles; legal values are 1 or 2 only.
- RDW_MODE, 0: same-address read-during-write result. 0 = old data; 1 = new data, merged per byte enable.
- INIT_VALUE, 0: MEM_DATA_WIDTH-bit value written to every word during the init sweep.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_wr_en  input  1  write request this cycle.
- i_wr_addr  input  MEM_ADDR_WIDTH  write address.
- i_wr_ben  input  MEM_DATA_SIZE_BYTES  per-byte write enable; bit k covers data[8k+7:8k].
- i_wr_data  input  MEM_DATA_WIDTH  write data.
- i_rd_en  input  1  read request this cycle.
- i_rd_addr  input  MEM_ADDR_WIDTH  read address.
- o_rd_data  output  MEM_DATA_WIDTH  read data; valid only when o_rd_valid=1.
- o_rd_valid  output  1  one-cycle strobe aligned with o_rd_data.
- o_init_done  output  1  high once the init sweep completes; user ports are live only then.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_rd_valid=0, o_rd_data=0, o_init_done=0.
  - All pipeline registers cleared; init counter=0; FSM enters INIT.
  - Memory array is not reset.
- FSM INIT:
  - Each cycle writes INIT_VALUE to mem[init_cnt], then init_cnt increments.
  - After writing address NUM_MEM_ADDR-1, FSM moves to READY and o_init_done=1 from the next cycle.
  - Sweep takes exactly NUM_MEM_ADDR cycles after reset release.
  - i_wr_en and i_rd_en are ignored (dropped, not queued); o_rd_valid stays 0.
- FSM READY:
  - Stays in READY until the next reset; o_init_done held at 1.
  - Write: on i_wr_en, byte k of mem[i_wr_addr] is updated iff i_wr_ben[k]. ben=0 leaves the word unchanged.
  - Read: on i_rd_en, data for i_rd_addr appears on o_rd_data with o_rd_valid=1 exactly READ_LATENCY cycles later.
    - READ_LATENCY=1: registered array output.
    - READ_LATENCY=2: one additional output register stage; valid bit pipelined alongside.
  - Throughput is one read and one write per cycle; back-to-back reads give back-to-back valid strobes.
  - o_rd_data holds its last value when o_rd_valid=0.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns new bytes where ben=1 and old bytes elsewhere.
  - Write always commits.
- Different addresses in the same cycle: independent, no interaction.
- A write at cycle t is visible to a read issued at cycle t+1 in both modes.
- Reset asserted mid-operation:
  - In-flight reads are discarded; o_rd_valid drops immediately.
  - Init sweep restarts from address 0 after release.
- Parameter checks: READ_LATENCY other than 1 or 2, or MEM_DATA_WIDTH not a multiple of 8, is a parameter-check failure at elaboration.

Test Plan:
- Init sweep, MEM_ADDR_WIDTH=4, INIT_VALUE=32'hDEADBEEF: release reset -> o_init_done rises after 16 cycles; reads of addr 0..15 all return DEADBEEF; a write to addr 3 issued during INIT is lost (addr 3 still reads DEADBEEF).
- Byte enables: write addr 5 data 32'h11223344 ben 4'b1111, then 32'hAABBCCDD ben 4'b0101 -> read addr 5 returns 32'h11BB33DD.
- Latency, READ_LATENCY=2: reads of addr 1,2,3 issued on consecutive cycles -> o_rd_valid high for 3 consecutive cycles starting 2 cycles after the first request, data in order.
- Collision: mem[7]=32'h00000000; same cycle write addr 7 data 32'hCAFEF00D ben 4'b0011 and read addr 7 -> RDW_MODE=0 returns 32'h00000000, RDW_MODE=1 returns 32'h0000F00D; a follow-up read returns 32'h0000F00D in both modes.
- Reset mid-read, READ_LATENCY=2: assert reset_n=0 one cycle after a read request -> o_rd_valid never pulses for that read; o_init_done=0 until the sweep reruns (16 cycles for MEM_ADDR_WIDTH=4).
- Independent ports: write addr 0 and read addr 9 in the same cycle for 50 random cycles -> read data matches a scoreboard model with no cross-port corruption.
